// File: rtl/trng_collector.sv
// Consumer for the ring-oscillator TRNG: warm-up, von Neumann debiasing, word packing onto a
// valid/ready port, and a repetition-count health test on the raw bit stream.
module trng_collector #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned RCT_LIMIT     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    output logic                  trng_en,
    input  logic                  trng_out,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  error_o,
    input  logic                  clear_error_i
);
    localparam int unsigned WarmW = $clog2(WARMUP_CYCLES);
    localparam int unsigned RctW  = $clog2(RCT_LIMIT + 1);
    localparam int unsigned BitW  = $clog2(WORD_WIDTH + 1);

    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
    localparam logic [RctW-1:0]  RctMax   = RctW'(RCT_LIMIT);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWarmup, StCollect, StHold} state_e;

    state_e                state_q;
    logic [WarmW-1:0]      warm_cnt_q;
    logic [RctW-1:0]       rct_cnt_q;
    logic [RctW-1:0]       rct_cnt_d;
    logic                  rct_bit_q;
    logic                  phase_q;
    logic                  pair_a_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [WORD_WIDTH-1:0] shreg_q;
    logic [WORD_WIDTH-1:0] shreg_d;
    logic                  rct_active;
    logic                  rct_trip;
    logic                  run;
    logic                  emit;
    logic                  word_full;
    logic                  xfer;

    always_comb begin
        // The first enabled cycle still carries the TRNG's disabled-state 0.
        rct_active = (state_q != StIdle) && !((state_q == StWarmup) && (warm_cnt_q == '0));
        rct_cnt_d  = ((rct_cnt_q != '0) && (trng_out == rct_bit_q)) ? rct_cnt_q + 1'b1
                                                                     : RctW'(1);
        rct_trip   = rct_active && (rct_cnt_d == RctMax);
        run        = enable_i && !rct_trip;
        xfer       = valid_o && ready_i;
        // (1,0) emits 1 and (0,1) emits 0, so the emitted bit is always the first of the pair.
        emit       = (state_q == StCollect) && phase_q && (pair_a_q != trng_out);
        shreg_d    = {shreg_q[WORD_WIDTH-2:0], pair_a_q};
        word_full  = emit && (bit_cnt_q == BitLast);
    end

    assign busy_o = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            trng_en    <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            error_o    <= 1'b0;
            warm_cnt_q <= '0;
            rct_cnt_q  <= '0;
            rct_bit_q  <= 1'b0;
            phase_q    <= 1'b0;
            pair_a_q   <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            if (xfer) begin
                valid_o <= 1'b0;
            end
            if (clear_error_i) begin
                error_o <= 1'b0;
            end
            if (rct_active) begin
                rct_cnt_q <= rct_cnt_d;
                rct_bit_q <= trng_out;
            end

            unique case (state_q)
                StIdle: begin
                    if (enable_i && !error_o) begin
                        state_q    <= StWarmup;
                        trng_en    <= 1'b1;
                        warm_cnt_q <= '0;
                        rct_cnt_q  <= '0;
                    end
                end
                StWarmup: begin
                    if (warm_cnt_q == WarmLast) begin
                        state_q   <= StCollect;
                        phase_q   <= 1'b0;
                        bit_cnt_q <= '0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + 1'b1;
                    end
                end
                StCollect: begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        pair_a_q <= trng_out;
                    end
                    if (emit && run) begin
                        if (!word_full) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (!valid_o || ready_i) begin
                            data_o    <= shreg_d;
                            valid_o   <= 1'b1;
                            bit_cnt_q <= '0;
                        end else begin
                            shreg_q <= shreg_d;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (xfer && run) begin
                        data_o    <= shreg_q;
                        valid_o   <= 1'b1;
                        state_q   <= StCollect;
                        phase_q   <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Abort overrides the per-state updates; a presented word survives a plain disable.
            if ((state_q != StIdle) && !run) begin
                state_q   <= StIdle;
                trng_en   <= 1'b0;
                phase_q   <= 1'b0;
                bit_cnt_q <= '0;
                if (rct_trip) begin
                    error_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: drives raw TRNG bits cycle by cycle and scores output words.
module tb_trng_collector;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable_i;
    logic         trng_en;
    logic         trng_out;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         busy_o;
    logic         error_o;
    logic         clear_error_i;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_sh;
    int           m_cnt;
    logic [W-1:0] prev_data;
    logic         prev_hold = 1'b0;
    logic [19:0]  stream;

    trng_collector #(
        .WORD_WIDTH   (W),
        .WARMUP_CYCLES(4),
        .RCT_LIMIT    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable_i),
        .trng_en      (trng_en),
        .trng_out     (trng_out),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .error_o      (error_o),
        .clear_error_i(clear_error_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one raw bit for the coming cycle, then step past the edge.
    task automatic tick(input logic b);
        trng_out = b;
        @(posedge clk);
        #1;
    endtask

    task automatic vn_model(input logic [19:0] bits, input int n);
        for (int i = n - 1; i > 0; i -= 2) begin
            if (bits[i] != bits[i-1]) begin
                m_sh = {m_sh[W-2:0], bits[i]};
                m_cnt++;
                if (m_cnt == W) begin
                    exp_q.push_back(m_sh);
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit model);
        if (model) exp_q.push_back(w);
        for (int i = W - 1; i >= 0; i--) begin
            tick(w[i]);
            tick(!w[i]);
        end
    endtask

    // Enable edge plus four warm-up cycles; the first warm-up bit is the TRNG's idle 0.
    task automatic start();
        enable_i = 1'b1;
        tick(1'b0);
        check("en_rise_trng_en", trng_en, 1);
        check("en_rise_busy", busy_o, 1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        m_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && valid_o && ready_i) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("sb_word", data_o, exp_q.pop_front());
        end
        if (!reset && prev_hold && valid_o) check("data_stable", data_o, prev_data);
        prev_hold = valid_o && !ready_i && !reset;
        prev_data = data_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable_i = 1'b0; trng_out = 1'b0; ready_i = 1'b1; clear_error_i = 1'b0;
        m_sh = '0; m_cnt = 0;
        repeat (3) tick(1'b0);
        check("rst_trng_en", trng_en, 0);
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_error", error_o, 0);
        reset = 1'b0;
        tick(1'b0);
        check("idle_busy", busy_o, 0);

        // Reference pair stream, ready held high.
        start();
        stream = 20'b10_01_10_10_00_01_11_01_01_10;
        vn_model(stream, 20);
        for (int i = 19; i >= 0; i--) begin
            if (i == 0) check("no_early_valid", valid_o, 0);
            tick(stream[i]);
        end
        check("word_valid", valid_o, 1);
        check("word_data", data_o, 8'b10110001);
        enable_i = 1'b0;
        tick(1'b0);
        check("valid_one_cycle", valid_o, 0);
        check("drop_trng_en", trng_en, 0);
        check("drop_busy", busy_o, 0);

        // Back-pressure into HOLD.
        ready_i = 1'b0;
        start();
        send_word(8'hA5, 1'b1);
        check("hold_w1_valid", valid_o, 1);
        check("hold_w1_data", data_o, 8'hA5);
        send_word(8'h3C, 1'b1);
        check("hold_busy", busy_o, 1);
        check("hold_keep_w1", data_o, 8'hA5);
        repeat (2) begin
            tick(1'b1);
            tick(1'b0);
        end
        check("hold_w1_after_wait", data_o, 8'hA5);
        ready_i = 1'b1;
        tick(1'b1);
        check("hold_w2_data", data_o, 8'h3C);
        check("hold_w2_valid", valid_o, 1);
        enable_i = 1'b0;
        tick(1'b0);
        check("hold_drained", valid_o, 0);

        // Disable with five bits of a word collected.
        start();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        enable_i = 1'b0;
        tick(1'b0);
        check("partial_trng_en", trng_en, 0);
        check("partial_busy", busy_o, 0);
        check("partial_no_valid", valid_o, 0);
        start();
        send_word(8'h06, 1'b1);
        check("fresh_word_valid", valid_o, 1);
        check("fresh_word_data", data_o, 8'h06);
        enable_i = 1'b0;
        tick(1'b0);

        // Repetition-count trip with a word presented.
        ready_i = 1'b0;
        start();
        send_word(8'h81, 1'b0);
        check("rct_pre_valid", valid_o, 1);
        check("rct_pre_data", data_o, 8'h81);
        repeat (7) tick(1'b1);
        check("rct_below_limit", error_o, 0);
        check("rct_below_busy", busy_o, 1);
        tick(1'b1);
        check("rct_error", error_o, 1);
        check("rct_trng_en", trng_en, 0);
        check("rct_valid", valid_o, 0);
        check("rct_busy", busy_o, 0);
        repeat (3) tick(1'b0);
        check("err_ignores_enable", busy_o, 0);
        check("err_trng_en_off", trng_en, 0);
        check("err_sticky", error_o, 1);
        clear_error_i = 1'b1;
        tick(1'b0);
        check("err_cleared", error_o, 0);
        check("err_clear_still_idle", busy_o, 0);
        clear_error_i = 1'b0;
        tick(1'b0);
        check("warmup_restart_en", trng_en, 1);
        check("warmup_restart_busy", busy_o, 1);
        enable_i = 1'b0;
        tick(1'b0);

        // Reset while HOLD has a word presented.
        start();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check("prerst_busy", busy_o, 1);
        check("prerst_valid", valid_o, 1);
        reset = 1'b1;
        enable_i = 1'b0;
        tick(1'b0);
        check("midrst_trng_en", trng_en, 0);
        check("midrst_data", data_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_error", error_o, 0);
        reset = 1'b0;
        tick(1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumer side of the ring-oscillator TRNG serial interface.
- Drives the TRNG enable and samples its 1-bit output each clock.
- After a warm-up period, removes bias with a von Neumann extractor and packs the resulting bits into WORD_WIDTH-bit words.
- Presents each word on a valid/ready port to the SoC register/bus wrapper, and runs a repetition-count health test on the raw bits.

Parameters:
- WORD_WIDTH, 32, bits per output word (2..32).
- WARMUP_CYCLES, 64, cycles raw bits are discarded after the TRNG is enabled (>=2).
- RCT_LIMIT, 32, number of consecutive identical raw bits that trips the health error (>=2).

Ports:
- clk  input  1  system clock, also the TRNG sampling clock
- reset  input  1  synchronous, active-high reset
- enable_i  input  1  request random data generation
- trng_en  output  1  enable to the TRNG oscillators
- trng_out  input  1  raw registered bit from the TRNG
- data_o  output  WORD_WIDTH  random word
- valid_o  output  1  data_o holds an untaken word
- ready_i  input  1  consumer accepts data_o
- busy_o  output  1  FSM not in IDLE
- error_o  output  1  sticky health-test failure
- clear_error_i  input  1  clears error_o

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high on port reset.
- Reset values: trng_en=0, data_o=0, valid_o=0, busy_o=0, error_o=0. FSM=IDLE, all counters=0.
- TRNG timing: trng_out is registered by the TRNG and is 0 while disabled, so the first meaningful bit arrives 1 cycle after trng_en rises.

FSM states:
- IDLE: trng_en=0. Goes to WARMUP when enable_i=1 and error_o=0.
- WARMUP: trng_en=1. A counter runs for WARMUP_CYCLES cycles, then the FSM goes to COLLECT. Raw bits feed the health test only.
- COLLECT: trng_en=1.
  - Raw bits are taken in non-overlapping pairs (a first, b second); the pair phase resets on entry to COLLECT.
  - (0,1) emits 0; (1,0) emits 1; (0,0) and (1,1) are discarded.
  - Each emitted bit shifts in: shreg <= {shreg[W-2:0], bit}, so the first emitted bit ends up as the MSB.
  - When the WORD_WIDTH-th bit is emitted:
    - if valid_o=0, or valid_o and ready_i are both high that cycle, the word loads into data_o, valid_o=1 the next cycle, the bit count resets, and the FSM stays in COLLECT;
    - otherwise the FSM goes to HOLD with the full word kept in shreg.
- HOLD: trng_en stays 1. Raw bits feed the health test only. On the valid_o&ready_i handshake, shreg loads into data_o, valid_o stays 1, and the FSM returns to COLLECT with the pair phase reset.

Output handshake:
- A transfer happens when valid_o & ready_i.
- valid_o drops the next cycle unless a new word loads that same cycle.
- data_o is stable while valid_o=1 and not yet transferred.
- Minimum latency from the last emitting pair to valid_o=1 is 1 cycle.

enable_i deasserted in WARMUP, COLLECT or HOLD:
- Next state is IDLE and trng_en=0 the next cycle.
- The partial word in shreg and a held HOLD word are discarded.
- An already-presented data_o/valid_o is retained until transferred.

Health test (repetition count):
- Active in WARMUP, COLLECT and HOLD, excluding the first cycle after trng_en rises.
- Counts consecutive identical raw bits.
- When the count reaches RCT_LIMIT: error_o=1 the next cycle, FSM to IDLE, trng_en=0, valid_o=0, partial word discarded.

Error handling:
- error_o is sticky; while it is set, enable_i is ignored.
- clear_error_i clears error_o the next cycle. If enable_i is still high, WARMUP restarts the cycle after that.
- If clear_error_i and a new error trip occur in the same cycle, the error wins.

Other rules:
- Reset asserted mid-operation returns everything to reset values the next cycle, regardless of state.
- busy_o = (state != IDLE).

Test Plan:
- Reset, then enable_i=1 with WARMUP_CYCLES=4 → trng_en=1 the cycle after enable; first pair sampled in the 5th cycle after entering WARMUP.
- WORD_WIDTH=8, ready_i=1, raw pairs 10,01,10,10,00,01,11,01,01,10 → data_o=8'b10110001, valid_o=1 one cycle after the last pair, high for exactly 1 cycle.
- ready_i=0 with continuous alternating raw bits → first word held on data_o, FSM enters HOLD, busy_o=1; on ready_i=1 the second word appears next cycle, and the first word is never corrupted.
- Raw stream of constant 1 for RCT_LIMIT=8 cycles in COLLECT → error_o=1, trng_en=0, valid_o=0; enable_i ignored until clear_error_i pulses, then WARMUP restarts.
- enable_i dropped mid-word (5 of 8 bits collected) → IDLE next cycle, trng_en=0; after re-enable and warm-up, the next word contains only new bits.
- reset pulse during HOLD with valid_o=1 → all outputs 0 the next cycle.
